dec_2_92: RTL and testbench

Decoder layer of the arrhythmia-detector autoencoder, the counterpart of the 92→2 encoder. It expands the 2-element latent vector back to 92 reconstructed samples: y[o] = b[o] + Σ_i w[o][i]·x[i], in Q4.11 fixed point. Outputs are computed on a time-multiplexed MAC array with LANES outputs per group. A start/busy/done_all handshake lets the top-level sequencer run it directly after the encoder.

---
 rtl/dec_2_92.sv | 130 +++++++++++++
 tb/tb_dec_2_92.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dec_2_92.sv
// dec_2_92: 2->92 decoder layer, y[o] = sat(b[o] + sum_i w[o][i]*x[i]) in signed Q4.11.
// LANES outputs share one MAC array per group; x, w and b are read live, never latched.
module dec_2_92 #(
   parameter int BITSIZE  = 16,
   parameter int FRAC     = 11,
   parameter int IN_SIZE  = 2,
   parameter int OUT_SIZE = 92,
   parameter int LANES    = 4,
   parameter int RELU     = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [BITSIZE*IN_SIZE-1:0]          x,
   input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
   input  logic [BITSIZE*OUT_SIZE-1:0]         b,
   output logic [BITSIZE*OUT_SIZE-1:0]         y,
   output logic                                busy,
   output logic                                done_all
);

   localparam int GROUPS = (OUT_SIZE + LANES - 1) / LANES;
   localparam int ACC_W  = 2*BITSIZE + $clog2(IN_SIZE + 1);
   localparam int SUM_W  = ACC_W + 1;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int KW     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

   localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
   localparam logic [KW-1:0] K_LAST = KW'(IN_SIZE - 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

   state_t                    state, state_n;
   logic [GW-1:0]             g;
   logic [KW-1:0]             k;
   logic                      accept;
   logic signed [ACC_W-1:0]   acc   [LANES];
   logic signed [BITSIZE-1:0] x_k;
   logic signed [BITSIZE-1:0] w_sel [LANES];
   logic signed [BITSIZE-1:0] b_sel [LANES];
   logic signed [2*BITSIZE-1:0] prod [LANES];
   logic signed [SUM_W-1:0]   sum   [LANES];
   logic signed [SUM_W-1:0]   shr   [LANES];
   logic signed [BITSIZE-1:0] res   [LANES];

   assign accept = start && (state == IDLE || state == DONE);

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (start) state_n = MAC;
         MAC:        if (k == K_LAST) state_n = WB;
         WB:         state_n = (g == G_LAST) ? DONE : MAC;
         default:    state_n = IDLE;
      endcase
   end

   // Operand selection: the current group g and latent index k steer wide muxes over w, b and x.
   always_comb begin
      x_k = '0;
      for (int i = 0; i < IN_SIZE; i++)
         if (k == KW'(i)) x_k = x[i*BITSIZE +: BITSIZE];
      for (int l = 0; l < LANES; l++) begin
         w_sel[l] = '0;
         b_sel[l] = '0;
         for (int gi = 0; gi < GROUPS; gi++)
            if (g == GW'(gi) && gi*LANES + l < OUT_SIZE) begin
               b_sel[l] = b[(gi*LANES + l)*BITSIZE +: BITSIZE];
               for (int i = 0; i < IN_SIZE; i++)
                  if (k == KW'(i)) w_sel[l] = w[((gi*LANES + l)*IN_SIZE + i)*BITSIZE +: BITSIZE];
            end
      end
   end

   // Bias is aligned to the product scale, then one arithmetic shift floors back to Q4.11.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         prod[l] = w_sel[l] * x_k;
         sum[l]  = SUM_W'(acc[l]) + (SUM_W'(b_sel[l]) <<< FRAC);
         shr[l]  = sum[l] >>> FRAC;
         if (shr[l] > SAT_MAX)      res[l] = {1'b0, {(BITSIZE-1){1'b1}}};
         else if (shr[l] < SAT_MIN) res[l] = {1'b1, {(BITSIZE-1){1'b0}}};
         else                       res[l] = shr[l][BITSIZE-1:0];
         if (RELU != 0 && res[l][BITSIZE-1]) res[l] = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; y is a register bank that
   // must read 0 out of reset, so unlike a RAM it is reset explicitly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         g        <= '0;
         k        <= '0;
         y        <= '0;
         busy     <= 1'b0;
         done_all <= 1'b0;
         for (int l = 0; l < LANES; l++) acc[l] <= '0;
      end else begin
         state    <= state_n;
         busy     <= (state_n == MAC) || (state_n == WB);
         done_all <= (state == DONE) && (state_n == DONE);
         case (state)
            IDLE, DONE: if (accept) begin
               g <= '0;
               k <= '0;
               for (int l = 0; l < LANES; l++) acc[l] <= '0;
            end
            MAC: begin
               for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
               k <= k + 1'b1;
            end
            WB: begin
               for (int gi = 0; gi < GROUPS; gi++)
                  for (int l = 0; l < LANES; l++)
                     if (g == GW'(gi) && gi*LANES + l < OUT_SIZE)
                        y[(gi*LANES + l)*BITSIZE +: BITSIZE] <= res[l];
               for (int l = 0; l < LANES; l++) acc[l] <= '0;
               k <= '0;
               if (g != G_LAST) g <= g + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dec_2_92.sv
// tb_dec_2_92: directed checks of the 2->92 decoder, a linear and a ReLU instance side by side.
// Expected values are hand-computed Q4.11 results.
module tb_dec_2_92;

   localparam int BS  = 16;
   localparam int IN  = 2;
   localparam int OUT = 92;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [BS*IN-1:0]     x;
   logic [BS*OUT*IN-1:0] w;
   logic [BS*OUT-1:0]    b;
   logic [BS*OUT-1:0]    y, y_r;
   logic               busy, done_all, busy_r, done_r;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dec_2_92 dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
      .y(y), .busy(busy), .done_all(done_all)
   );

   dec_2_92 #(.RELU(1)) dut_relu (
      .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
      .y(y_r), .busy(busy_r), .done_all(done_r)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] yw(input logic [BS*OUT-1:0] v, input int o);
      return v[o*BS +: BS];
   endfunction

   task automatic load(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] w0,
                       input logic [15:0] w1, input logic [15:0] bv, input bit ramp);
      x[0 +: BS]  = x0;
      x[BS +: BS] = x1;
      for (int o = 0; o < OUT; o++) begin
         w[(o*IN)*BS +: BS]     = ramp ? 16'(16*o) : w0;
         w[(o*IN + 1)*BS +: BS] = w1;
         b[o*BS +: BS]          = bv;
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] exp, input logic [15:0] exp_r);
      for (int o = 0; o < OUT; o++) begin
         check($sformatf("%s[%0d]", tag, o), yw(y, o), exp);
         check($sformatf("%s_relu[%0d]", tag, o), yw(y_r, o), exp_r);
      end
   endtask

   task automatic check_ramp(input string tag);
      for (int o = 0; o < OUT; o++) begin
         check($sformatf("%s[%0d]", tag, o), yw(y, o), 16'(16*o));
         check($sformatf("%s_relu[%0d]", tag, o), yw(y_r, o), 16'(16*o));
      end
   endtask

   // One pass from a start pulse; optional ignored start at glitch_at and group-visibility probes.
   task automatic run_pass(input int glitch_at, input bit grp_chk,
                           input logic [15:0] new_v, input logic [15:0] old_v);
      int cycles = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_done_low", done_all, 0);
      while (!done_all && cycles < 200) begin
         start = (cycles == glitch_at);
         @(posedge clk); #1;
         cycles++;
         start = 1'b0;
         if (cycles == 69) check("gap_done_low", done_all, 0);
         if (grp_chk && cycles == 3) begin
            check("grp0_y0", yw(y, 0), new_v);
            check("grp0_y3", yw(y, 3), new_v);
            check("grp1_y4_old", yw(y, 4), old_v);
         end
         if (grp_chk && cycles == 6) begin
            check("grp1_y4", yw(y, 4), new_v);
            check("grp2_y8_old", yw(y, 8), old_v);
         end
      end
      check("done_latency", cycles, 70);
      check("busy_at_done", busy, 0);
      check("relu_done", done_r, 1);
   endtask

   initial begin
      x = '0;
      w = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_y_zero", 32'(|y), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_all, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done_all, 0);

      // 1.0*0.1001*2 + 0.5 -> 1434
      load(16'd2048, 16'd2048, 16'd205, 16'd205, 16'd1024, 1'b0);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_all("basic", 16'd1434, 16'd1434);

      // Restart straight from DONE with b = 1.0 -> 410 + 2048
      for (int o = 0; o < OUT; o++) b[o*BS +: BS] = 16'd2048;
      run_pass(-1, 1'b1, 16'd2458, 16'd1434);
      check_all("restart", 16'd2458, 16'd2458);

      // Index mapping, with a start pulse mid-pass that must be ignored
      load(16'd2048, 16'd0, 16'd0, 16'd1000, 16'd0, 1'b1);
      run_pass(10, 1'b0, 16'd0, 16'd0);
      check_ramp("ramp");

      load(16'd14336, 16'd14336, 16'd14336, 16'd14336, 16'd0, 1'b0);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_all("sat_pos", 16'h7FFF, 16'h7FFF);

      load(16'hC000, 16'hC000, 16'd14336, 16'd14336, 16'd0, 1'b0);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_all("sat_neg", 16'h8000, 16'h0000);

      load(16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 1'b0);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_all("trunc_pos", 16'h0000, 16'h0000);

      load(16'hFFFF, 16'd0, 16'd1, 16'd0, 16'd0, 1'b0);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_all("trunc_neg", 16'hFFFF, 16'h0000);

      // Asynchronous reset between edges, 30 cycles into a pass
      load(16'd2048, 16'd2048, 16'd205, 16'd205, 16'd1024, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("abort_y_zero", 32'(|y), 0);
      check("abort_relu_y_zero", 32'(|y_r), 0);
      check("abort_busy", busy, 0);
      check("abort_done", done_all, 0);
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      load(16'd2048, 16'd0, 16'd0, 16'd1000, 16'd0, 1'b1);
      run_pass(-1, 1'b0, 16'd0, 16'd0);
      check_ramp("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
